// File: rtl/fanctrl_cfg_pkg.sv
// Shared constants, FSM states and helpers for the fan-control sequencer.
package fanctrl_cfg_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_A0     = 4'd1;
  localparam logic [3:0] ADDR_A1     = 4'd2;
  localparam logic [3:0] ADDR_B0     = 4'd3;
  localparam logic [3:0] ADDR_B1     = 4'd4;
  localparam logic [3:0] ADDR_B2     = 4'd5;
  localparam logic [3:0] ADDR_SET    = 4'd6;
  localparam logic [3:0] ADDR_MIN    = 4'd7;
  localparam logic [3:0] ADDR_PERIOD = 4'd8;

  localparam int PERIOD_RST = 255;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    COMMIT
  } state_t;

  function automatic logic [1:0] nib_count(
    input logic [3:0] addr
  );
    return (addr == ADDR_PERIOD) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/fanctrl_cfg_if.sv
// Nibble-serial configuration channel with valid/ready handshake.
interface fanctrl_cfg_if;
  logic       cfg_valid_i;
  logic [3:0] cfg_data_i;
  logic       cfg_ready_o;
  logic       cfg_err_o;

  modport master (
    output cfg_valid_i, cfg_data_i,
    input  cfg_ready_o, cfg_err_o
  );

  modport slave (
    input  cfg_valid_i, cfg_data_i,
    output cfg_ready_o, cfg_err_o
  );
endinterface

// File: rtl/fanctrl_strobe_gen.sv
// PWM / PID clock-enable prescaler with registered strobes.
module fanctrl_strobe_gen #(
  parameter int PWM_DIV = 4,
  parameter int PID_DIV = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic run_i,
  output logic clk_en_PWM_o,
  output logic clk_en_PID_o
);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DW = (PID_DIV > 1) ? $clog2(PID_DIV) : 1;
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_DIV - 1);
  localparam logic [DW-1:0] PID_LAST = DW'(PID_DIV - 1);

  logic [PW-1:0] pwm_cnt;
  logic [DW-1:0] pid_cnt;
  logic          wrap;

  assign wrap = (pwm_cnt == PWM_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_cnt      <= '0;
      pid_cnt      <= '0;
      clk_en_PWM_o <= 1'b0;
      clk_en_PID_o <= 1'b0;
    end else if (!run_i) begin
      pwm_cnt      <= '0;
      pid_cnt      <= '0;
      clk_en_PWM_o <= 1'b0;
      clk_en_PID_o <= 1'b0;
    end else begin
      clk_en_PWM_o <= wrap;
      clk_en_PID_o <= wrap && (pid_cnt == PID_LAST);
      pwm_cnt      <= wrap ? '0 : pwm_cnt + PW'(1);
      if (wrap)
        pid_cnt <= (pid_cnt == PID_LAST) ? '0 : pid_cnt + DW'(1);
    end
  end
endmodule

// File: rtl/fanctrl_sequencer.sv
// Fan-control config sequencer: nibble frames -> shadow -> active at PID steps.
// Optional frame timeout: FANCTRL_CFG_TIMEOUT_EN.
module fanctrl_sequencer
  import fanctrl_cfg_pkg::*;
#(
  parameter int ADC_BITWIDTH   = 8,
  parameter int REG_BITWIDTH   = 5,
  parameter int PWM_DIV        = 4,
  parameter int PID_DIV        = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  fanctrl_cfg_if.slave                   cfg,
  output logic                           run_o,
  output logic                           clk_en_PWM_o,
  output logic                           clk_en_PID_o,
  output logic signed [REG_BITWIDTH-1:0] a0_o,
  output logic signed [REG_BITWIDTH-1:0] a1_o,
  output logic signed [REG_BITWIDTH-1:0] b0_o,
  output logic signed [REG_BITWIDTH-1:0] b1_o,
  output logic signed [REG_BITWIDTH-1:0] b2_o,
  output logic [ADC_BITWIDTH-1:0]        SET_value_o,
  output logic [ADC_BITWIDTH-1:0]        minCounterValue_o,
  output logic [ADC_BITWIDTH:0]          periodCounterValue_o
);
  localparam int RW = REG_BITWIDTH;
  localparam int AW = ADC_BITWIDTH;
  localparam logic [AW:0] PER_RST = (AW+1)'(PERIOD_RST);

  if (PWM_DIV < 2 || PID_DIV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("fanctrl_sequencer: illegal divider/timeout parameter");
  end

  state_t      state;
  logic [3:0]  addr;
  logic [1:0]  idx;
  logic [11:0] sreg;
  logic        ready;
  logic        err;
  logic        xfer;
  logic        commit;
  logic        bad;
  logic [2:0]  ci;
  logic        unused_bits;

  logic [4:0][RW-1:0] co_sh, co_nx, co_act;
  logic [AW-1:0] set_sh, set_nx, set_act;
  logic [AW-1:0] min_sh, min_nx, min_act;
  logic [AW:0]   per_sh, per_nx, per_act;

  assign xfer        = cfg.cfg_valid_i & ready;
  assign commit      = (state == COMMIT);
  assign bad         = (addr > ADDR_PERIOD);
  assign ci          = 3'(addr - ADDR_A0);
  assign unused_bits = ^sreg[11:AW+1];

  assign cfg.cfg_ready_o = ready;
  assign cfg.cfg_err_o   = err;

  `ifdef FANCTRL_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt;
  `endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      addr  <= '0;
      idx   <= '0;
      sreg  <= '0;
      ready <= 1'b1;
      err   <= 1'b0;
      run_o <= 1'b0;
      `ifdef FANCTRL_CFG_TIMEOUT_EN
      idle_cnt <= '0;
      `endif
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            addr  <= cfg.cfg_data_i;
            idx   <= '0;
            sreg  <= '0;
            state <= DATA;
            `ifdef FANCTRL_CFG_TIMEOUT_EN
            idle_cnt <= '0;
            `endif
          end
        end
        DATA: begin
          if (xfer) begin
            sreg <= sreg | (12'(cfg.cfg_data_i) << {idx, 2'b00});
            idx  <= idx + 2'd1;
            `ifdef FANCTRL_CFG_TIMEOUT_EN
            idle_cnt <= '0;
            `endif
            if (idx == nib_count(addr) - 2'd1) begin
              state <= COMMIT;
              ready <= 1'b0;
              err   <= bad;
            end
          end
          `ifdef FANCTRL_CFG_TIMEOUT_EN
          else if (idle_cnt == TO_LAST) begin
            idle_cnt <= '0;
            err      <= 1'b1;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
          `endif
        end
        COMMIT: begin
          if (addr == ADDR_CTRL)
            run_o <= sreg[0];
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    co_nx  = co_sh;
    set_nx = set_sh;
    min_nx = min_sh;
    per_nx = per_sh;
    if (commit) begin
      if (addr >= ADDR_A0 && addr <= ADDR_B2)
        co_nx[ci] = sreg[RW-1:0];
      if (addr == ADDR_SET)
        set_nx = sreg[AW-1:0];
      if (addr == ADDR_MIN)
        min_nx = sreg[AW-1:0];
      if (addr == ADDR_PERIOD)
        per_nx = sreg[AW:0];
    end
  end

  // While stopped a commit goes straight through; while running only
  // the end of a PID-step cycle moves the (pre-commit) shadow set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      co_sh   <= '0;
      set_sh  <= '0;
      min_sh  <= '0;
      per_sh  <= PER_RST;
      co_act  <= '0;
      set_act <= '0;
      min_act <= '0;
      per_act <= PER_RST;
    end else begin
      co_sh  <= co_nx;
      set_sh <= set_nx;
      min_sh <= min_nx;
      per_sh <= per_nx;
      if (commit && !bad && !run_o) begin
        co_act  <= co_nx;
        set_act <= set_nx;
        min_act <= min_nx;
        per_act <= per_nx;
      end else if (run_o && clk_en_PID_o) begin
        co_act  <= co_sh;
        set_act <= set_sh;
        min_act <= min_sh;
        per_act <= per_sh;
      end
    end
  end

  assign a0_o                 = co_act[0];
  assign a1_o                 = co_act[1];
  assign b0_o                 = co_act[2];
  assign b1_o                 = co_act[3];
  assign b2_o                 = co_act[4];
  assign SET_value_o          = set_act;
  assign minCounterValue_o    = min_act;
  assign periodCounterValue_o = per_act;

  fanctrl_strobe_gen #(
    .PWM_DIV (PWM_DIV),
    .PID_DIV (PID_DIV)
  ) u_strobe (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .run_i        (run_o),
    .clk_en_PWM_o (clk_en_PWM_o),
    .clk_en_PID_o (clk_en_PID_o)
  );
endmodule

// File: tb/tb_fanctrl_sequencer.sv
// Randomized bench for fanctrl_sequencer against a frame/run-length model.
module tb_fanctrl_sequencer;
  localparam int ADC = 8;
  localparam int RW  = 5;
  localparam int PWM_DIV = 4;
  localparam int PID_DIV = 3;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fanctrl_cfg_if cfg();

  logic run, pwm, pid;
  logic signed [RW-1:0] a0, a1, b0, b1, b2;
  logic [ADC-1:0] setv, minv;
  logic [ADC:0] per;

  fanctrl_sequencer #(
    .ADC_BITWIDTH   (ADC),
    .REG_BITWIDTH   (RW),
    .PWM_DIV        (PWM_DIV),
    .PID_DIV        (PID_DIV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .cfg                  (cfg),
    .run_o                (run),
    .clk_en_PWM_o         (pwm),
    .clk_en_PID_o         (pid),
    .a0_o                 (a0),
    .a1_o                 (a1),
    .b0_o                 (b0),
    .b1_o                 (b1),
    .b2_o                 (b2),
    .SET_value_o          (setv),
    .minCounterValue_o    (minv),
    .periodCounterValue_o (per)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // model: register index 1..8 = a0,a1,b0,b1,b2,SET,MIN,PERIOD
  bit m_run, m_pwm, m_pid, m_commit, m_to;
  int m_runlen, m_caddr, m_cval, m_idle;
  int q[$];
  logic [8:0] sh[9];
  logic [8:0] act[9];

  function automatic logic [8:0] fit(input int a, input int v);
    if (a <= 5) return 9'(v & 31);
    if (a <= 7) return 9'(v & 255);
    return 9'(v & 511);
  endfunction

  task automatic m_reset();
    m_run = 0; m_pwm = 0; m_pid = 0; m_commit = 0; m_to = 0;
    m_runlen = 0; m_caddr = 0; m_cval = 0; m_idle = 0;
    q.delete();
    for (int i = 0; i < 9; i++) begin
      sh[i] = 0;
      act[i] = 0;
    end
    sh[8] = 255;
    act[8] = 255;
  endtask

  task automatic m_step();
    bit orun, opid, ocm;
    int need;
    orun = m_run; opid = m_pid; ocm = m_commit;
    if (orun && opid)
      for (int i = 1; i < 9; i++) act[i] = sh[i];
    if (ocm) begin
      if (m_caddr == 0) m_run = m_cval[0];
      else if (m_caddr <= 8) sh[m_caddr] = fit(m_caddr, m_cval);
      if (!orun && m_caddr <= 8)
        for (int i = 1; i < 9; i++) act[i] = sh[i];
    end
    m_runlen = orun ? m_runlen + 1 : 0;
    m_pwm = orun && (m_runlen % PWM_DIV == 0);
    m_pid = m_pwm && ((m_runlen / PWM_DIV) % PID_DIV == 0);
    m_commit = 0;
    m_to = 0;
    if (cfg.cfg_valid_i && !ocm) begin
      q.push_back(int'(cfg.cfg_data_i));
      m_idle = 0;
      need = (q[0] == 8) ? 3 : 2;
      if (q.size() == need + 1) begin
        m_caddr = q[0];
        m_cval = 0;
        for (int i = 0; i < need; i++) m_cval |= q[i+1] << (4 * i);
        q.delete();
        m_commit = 1;
      end
    end
`ifdef FANCTRL_CFG_TIMEOUT_EN
    else if (q.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        q.delete();
        m_idle = 0;
        m_to = 1;
      end
    end
`endif
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) m_reset();
    else m_step();

  always @(negedge clk) begin
    if (rstn) begin
      chk("ready", cfg.cfg_ready_o, !m_commit);
      chk("err", cfg.cfg_err_o, (m_commit && m_caddr > 8) || m_to);
      chk("run", run, m_run);
      chk("pwm", pwm, m_pwm);
      chk("pid", pid, m_pid);
      chk("a0", $unsigned(a0), act[1]);
      chk("a1", $unsigned(a1), act[2]);
      chk("b0", $unsigned(b0), act[3]);
      chk("b1", $unsigned(b1), act[4]);
      chk("b2", $unsigned(b2), act[5]);
      chk("set", setv, act[6]);
      chk("min", minv, act[7]);
      chk("period", per, act[8]);
    end
  end

  task automatic send_nib(input logic [3:0] d);
    int g;
    bit ok;
    g = 0;
    do begin
      @(negedge clk);
      cfg.cfg_valid_i = 1'b1;
      cfg.cfg_data_i = d;
      ok = cfg.cfg_ready_o;
      g++;
    end while (!ok && g < 8);
    if (!ok) chk("ready_wait", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg.cfg_valid_i = 1'b0;
      cfg.cfg_data_i = 4'($urandom);
    end
  endtask

  task automatic send_frame(input int a, input int v, input bit gaps);
    int need;
    need = (a == 8) ? 3 : 2;
    send_nib(4'(a));
    for (int i = 0; i < need; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_nib(4'(v >> (4 * i)));
    end
  endtask

  int first_pwm, npwm, npid, g, nerr;

  initial begin
    cfg.cfg_valid_i = 1'b0;
    cfg.cfg_data_i = 4'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_period", per, 9'd255);
    chk("rst_a0", $unsigned(a0), 0);
    chk("rst_ready", cfg.cfg_ready_o, 1);
    chk("rst_strobes", {pwm, pid, run}, 0);

    // start running, measure strobe grid
    send_nib(0); send_nib(1); send_nib(0);
    idle(2);
    chk("run_on", run, 1);
    first_pwm = -1; npwm = 0; npid = 0;
    for (int i = 0; i < 48; i++) begin
      if (pwm) begin
        npwm++;
        if (first_pwm < 0) first_pwm = i;
      end
      if (pid) npid++;
      @(negedge clk);
    end
    chk("first_pwm", first_pwm, 4);
    chk("n_pwm", npwm, 11);
    chk("n_pid", npid, 3);

    // a0 = 0x1B held until the next PID boundary
    send_nib(1); send_nib(4'hB); send_nib(1);
    idle(2);
    chk("a0_held", $unsigned(a0), 0);
    idle(14);
    chk("a0_new", $unsigned(a0), 5'b11011);

    // commit lands exactly on a PID-strobe cycle
    g = 0;
    while (!m_pid && g < 40) begin
      idle(1);
      g++;
    end
    chk("pid_found", m_pid, 1);
    idle(8);
    send_nib(1); send_nib(4'hA); send_nib(0);
    idle(1);
    chk("coinc_ready", cfg.cfg_ready_o, 0);
    chk("coinc_pid", pid, 1);
    idle(12);
    chk("deferred_old", $unsigned(a0), 5'b11011);
    idle(1);
    chk("deferred_new", $unsigned(a0), 5'b01010);

    // stop, then period write goes straight to active
    send_frame(0, 0, 0);
    idle(3);
    send_nib(8); send_nib(4'hF); send_nib(4'hF); send_nib(1);
    idle(1);
    chk("commit_ready", cfg.cfg_ready_o, 0);
    idle(1);
    chk("period_1ff", per, 9'h1FF);

    // invalid address
    send_nib(4'hC); send_nib(3); send_nib(4);
    idle(1);
    chk("bad_err", cfg.cfg_err_o, 1);
    idle(1);
    chk("bad_err_end", cfg.cfg_err_o, 0);
    chk("bad_keep_per", per, 9'h1FF);
    chk("bad_keep_a0", $unsigned(a0), 5'b01010);

`ifdef FANCTRL_CFG_TIMEOUT_EN
    send_nib(1); send_nib(7);
    nerr = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (cfg.cfg_err_o) nerr++;
    end
    chk("timeout_err", nerr, 1);
    send_frame(2, 8'h13, 0);
    idle(2);
    chk("after_to_a1", $unsigned(a1), 5'h13);
`endif

    for (int f = 0; f < 200; f++) begin
      int a;
      a = $urandom_range(0, 15);
      send_frame(a, int'($urandom_range(0, 4095)), 1'($urandom));
      idle($urandom_range(0, 3));
    end

    // reset mid-frame
    send_frame(0, 1, 0);
    idle(2);
    send_frame(3, 8'h0F, 0);
    idle(40);
    send_nib(1); send_nib(5);
    @(negedge clk);
    cfg.cfg_valid_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_period", per, 9'd255);
    chk("mid_rst_b0", $unsigned(b0), 0);
    chk("mid_rst_ready", cfg.cfg_ready_o, 1);
    chk("mid_rst_run", {run, pwm, pid}, 0);
    @(negedge clk);
    rstn = 1'b1;
    send_frame(6, 8'h5A, 0);
    idle(2);
    chk("post_rst_set", setv, 8'h5A);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
